// File: rtl/shift_issue_pkg.sv
// Shared types and widths for the shift-µop issue buffer.
package shift_issue_pkg;

  localparam int unsigned RB   = 1;
  localparam int unsigned PRW  = 5 + RB;
  localparam int unsigned NPR  = 32 * (2 ** RB);
  localparam int unsigned XLEN = 64;

  // Renamed µop as offered by dispatch.
  typedef struct packed {
    logic            sll;
    logic            srl;
    logic            sra;
    logic [PRW-1:0]  rd0;
    logic [PRW-1:0]  rs1;
    logic [PRW-1:0]  rs2;
    logic [XLEN-1:0] imm;
    logic            is_imm;
    logic            is32w;
  } shift_info_t;

  // Operand-resolved bundle handed to the shift execute unit.
  typedef struct packed {
    logic            sll;
    logic            srl;
    logic            sra;
    logic [PRW-1:0]  rd0;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            is32w;
  } shift_exe_t;

  localparam int unsigned INFO_DW = $bits(shift_info_t);
  localparam int unsigned EXE_DW  = $bits(shift_exe_t);

endpackage

// File: rtl/shift_issue_fifo.sv
// In-order entry storage with wrap-bit pointers; head is visible combinationally.
module shift_issue_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned DP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head_c,
  output logic         full_c,
  output logic         empty_c
);

  localparam int unsigned AW = $clog2(DP);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W-1:0]  mem [DP];

  // Pointer update; flush returns both pointers to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_c  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/shift_issue.sv
// In-order issue buffer for shift µops: waits on physical source readiness,
// reads operands for the head and registers the execute bundle.
module shift_issue
  import shift_issue_pkg::*;
#(
  parameter int unsigned DP = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              flush,
  input  logic              dispatch_vaild,
  output logic              dispatch_ready,
  input  shift_info_t       dispatch_info,
  output logic [PRW-1:0]    rs1_raddr,
  output logic [PRW-1:0]    rs2_raddr,
  input  logic [XLEN-1:0]   rs1_rdata,
  input  logic [XLEN-1:0]   rs2_rdata,
  input  logic [NPR-1:0]    phy_ready,
  output logic              shift_exeparam_vaild,
  output shift_exe_t        shift_exeparam
);

  shift_info_t head_c;
  shift_exe_t  exe_nxt_c;
  logic        full_c;
  logic        empty_c;
  logic        push_c;
  logic        issue_c;
  logic        rs1_ok_c;
  logic        rs2_ok_c;

  shift_issue_fifo #(
    .W  (INFO_DW),
    .DP (DP)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTn),
    .push    (push_c),
    .pop     (issue_c),
    .flush   (flush),
    .wdata   (dispatch_info),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  assign dispatch_ready = ~full_c;
  assign push_c         = dispatch_vaild & ~full_c & ~flush;

  assign rs1_raddr = head_c.rs1;
  assign rs2_raddr = head_c.rs2;

  // Register 0 is architectural zero and always ready.
  assign rs1_ok_c = phy_ready[head_c.rs1] | (head_c.rs1 == '0);
  assign rs2_ok_c = head_c.is_imm | phy_ready[head_c.rs2] | (head_c.rs2 == '0);
  assign issue_c  = ~empty_c & rs1_ok_c & rs2_ok_c & ~flush;

  always_comb begin
    exe_nxt_c       = '0;
    exe_nxt_c.sll   = head_c.sll;
    exe_nxt_c.srl   = head_c.srl;
    exe_nxt_c.sra   = head_c.sra;
    exe_nxt_c.rd0   = head_c.rd0;
    exe_nxt_c.is32w = head_c.is32w;
    exe_nxt_c.op1   = (head_c.rs1 == '0) ? '0 : rs1_rdata;
    if (head_c.is_imm)
      exe_nxt_c.op2 = head_c.imm;
    else
      exe_nxt_c.op2 = (head_c.rs2 == '0) ? '0 : rs2_rdata;
  end

  // Bundle holds its last value when nothing issues.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shift_exeparam_vaild <= 1'b0;
      shift_exeparam       <= '0;
    end else begin
      shift_exeparam_vaild <= issue_c;
      if (issue_c) shift_exeparam <= exe_nxt_c;
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Directed bench for shift_issue with a small regfile model.
module tb_shift_issue;
  import shift_issue_pkg::*;

  localparam int unsigned DP = 4;
  localparam int unsigned CW = EXE_DW;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic            flush;
  logic            dispatch_vaild;
  logic            dispatch_ready;
  shift_info_t     dispatch_info;
  logic [PRW-1:0]  rs1_raddr;
  logic [PRW-1:0]  rs2_raddr;
  logic [XLEN-1:0] rs1_rdata;
  logic [XLEN-1:0] rs2_rdata;
  logic [NPR-1:0]  phy_ready;
  logic            shift_exeparam_vaild;
  shift_exe_t      shift_exeparam;

  logic [XLEN-1:0] rf [NPR];

  int n_checks = 0;
  int n_fail   = 0;

  shift_issue #(.DP(DP)) dut (
    .CLK                  (CLK),
    .RSTn                 (RSTn),
    .flush                (flush),
    .dispatch_vaild       (dispatch_vaild),
    .dispatch_ready       (dispatch_ready),
    .dispatch_info        (dispatch_info),
    .rs1_raddr            (rs1_raddr),
    .rs2_raddr            (rs2_raddr),
    .rs1_rdata            (rs1_rdata),
    .rs2_rdata            (rs2_rdata),
    .phy_ready            (phy_ready),
    .shift_exeparam_vaild (shift_exeparam_vaild),
    .shift_exeparam       (shift_exeparam)
  );

  always #5 CLK = ~CLK;

  assign rs1_rdata = rf[rs1_raddr];
  assign rs2_rdata = rf[rs2_raddr];

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  function automatic shift_info_t mk_info(input logic [2:0] op, input int rd, input int rs1,
                                          input int rs2, input logic [63:0] imm,
                                          input logic is_imm, input logic is32w);
    shift_info_t i;
    i.sll    = op[2];
    i.srl    = op[1];
    i.sra    = op[0];
    i.rd0    = PRW'(rd);
    i.rs1    = PRW'(rs1);
    i.rs2    = PRW'(rs2);
    i.imm    = imm;
    i.is_imm = is_imm;
    i.is32w  = is32w;
    return i;
  endfunction

  function automatic shift_exe_t mk_exe(input logic [2:0] op, input int rd, input logic [63:0] op1,
                                        input logic [63:0] op2, input logic is32w);
    shift_exe_t e;
    e.sll   = op[2];
    e.srl   = op[1];
    e.sra   = op[0];
    e.rd0   = PRW'(rd);
    e.op1   = op1;
    e.op2   = op2;
    e.is32w = is32w;
    return e;
  endfunction

  function automatic logic [2:0] stream_op(input int k);
    logic [2:0] base;
    base = 3'b100;
    return base >> (k % 3);
  endfunction

  initial begin
    for (int i = 0; i < int'(NPR); i++) rf[i] = 64'h1000 + 64'(i);
    rf[0] = 64'hDEAD;
    rf[5] = 64'h1;
    phy_ready      = '0;
    flush          = 1'b0;
    dispatch_vaild = 1'b0;
    dispatch_info  = '0;

    // Reset state
    smp();
    check("rst_ready", CW'(dispatch_ready), CW'(1'b1));
    check("rst_vaild", CW'(shift_exeparam_vaild), CW'(1'b0));
    check("rst_exe", CW'(shift_exeparam), CW'(0));
    step();
    RSTn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      smp();
      check("idle", CW'({dispatch_ready, shift_exeparam_vaild}), CW'(2'b10));
    end

    // Single SLL with immediate, earliest issue one edge after push
    phy_ready[5] = 1'b1;
    phy_ready[6] = 1'b1;
    dispatch_info  = mk_info(3'b100, 3, 5, 0, 64'd4, 1'b1, 1'b0);
    dispatch_vaild = 1'b1;
    step();
    dispatch_vaild = 1'b0;
    smp();
    check("sll_nobypass", CW'(shift_exeparam_vaild), CW'(1'b0));
    step();
    smp();
    check("sll_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
    check("sll_exe", CW'(shift_exeparam), CW'(mk_exe(3'b100, 3, 64'h1, 64'd4, 1'b0)));
    step();
    smp();
    check("sll_done", CW'(shift_exeparam_vaild), CW'(1'b0));
    check("sll_hold", CW'(shift_exeparam), CW'(mk_exe(3'b100, 3, 64'h1, 64'd4, 1'b0)));

    // Blocked SRA head keeps ready SRL behind it
    dispatch_info  = mk_info(3'b001, 8, 7, 0, 64'd2, 1'b1, 1'b1);
    dispatch_vaild = 1'b1;
    step();
    dispatch_info  = mk_info(3'b010, 9, 5, 6, 64'hFF, 1'b0, 1'b0);
    step();
    dispatch_vaild = 1'b0;
    for (int c = 0; c < 3; c++) begin
      smp();
      check("blocked", CW'(shift_exeparam_vaild), CW'(1'b0));
      step();
    end
    phy_ready[7] = 1'b1;
    step();
    smp();
    check("sra_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
    check("sra_exe", CW'(shift_exeparam), CW'(mk_exe(3'b001, 8, 64'h1007, 64'd2, 1'b1)));
    step();
    smp();
    check("srl_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
    check("srl_exe", CW'(shift_exeparam), CW'(mk_exe(3'b010, 9, 64'h1, 64'h1006, 1'b0)));
    step();
    smp();
    check("order_done", CW'(shift_exeparam_vaild), CW'(1'b0));

    // x0 sources read as zero and count as ready
    dispatch_info  = mk_info(3'b010, 4, 0, 0, 64'd77, 1'b0, 1'b0);
    dispatch_vaild = 1'b1;
    step();
    dispatch_vaild = 1'b0;
    step();
    smp();
    check("x0_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
    check("x0_exe", CW'(shift_exeparam), CW'(mk_exe(3'b010, 4, 64'h0, 64'h0, 1'b0)));

    // Fill to DP with unready entries
    for (int k = 0; k < int'(DP); k++) begin
      dispatch_info  = mk_info(3'b100, 20 + k, 10 + k, 0, 64'(k + 1), 1'b1, 1'b0);
      dispatch_vaild = 1'b1;
      step();
    end
    smp();
    check("full_ready", CW'(dispatch_ready), CW'(1'b0));
    check("full_vaild", CW'(shift_exeparam_vaild), CW'(1'b0));
    dispatch_info = mk_info(3'b100, 30, 5, 0, 64'd99, 1'b1, 1'b0);
    step();
    step();
    smp();
    check("full_hold_ready", CW'(dispatch_ready), CW'(1'b0));
    check("full_hold_vaild", CW'(shift_exeparam_vaild), CW'(1'b0));

    // Full: issue and offered push on the same edge; push must be rejected
    phy_ready[10] = 1'b1;
    step();
    dispatch_vaild = 1'b0;
    phy_ready[13:11] = 3'b111;
    smp();
    check("pop_ready", CW'(dispatch_ready), CW'(1'b1));
    check("drain0_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
    check("drain0_exe", CW'(shift_exeparam), CW'(mk_exe(3'b100, 20, 64'h100A, 64'd1, 1'b0)));
    for (int k = 1; k < int'(DP); k++) begin
      step();
      smp();
      check("drain_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
      check("drain_exe", CW'(shift_exeparam),
            CW'(mk_exe(3'b100, 20 + k, 64'h100A + 64'(k), 64'(k + 1), 1'b0)));
    end
    step();
    smp();
    check("rejected_push", CW'(shift_exeparam_vaild), CW'(1'b0));

    // Back-to-back stream across pointer wrap
    for (int k = 0; k < 6; k++) begin
      dispatch_info  = mk_info(stream_op(k), 40 + k, 6, 0, 64'(100 + k), 1'b1, 1'(k));
      dispatch_vaild = 1'b1;
      step();
      smp();
      if (k > 0) begin
        check("stream_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
        check("stream_exe", CW'(shift_exeparam),
              CW'(mk_exe(stream_op(k - 1), 39 + k, 64'h1006, 64'(99 + k), 1'(k - 1))));
      end else begin
        check("stream_first", CW'(shift_exeparam_vaild), CW'(1'b0));
      end
    end
    dispatch_vaild = 1'b0;
    step();
    smp();
    check("stream_last", CW'(shift_exeparam),
          CW'(mk_exe(stream_op(5), 45, 64'h1006, 64'd105, 1'b1)));
    step();
    smp();
    check("stream_idle", CW'(shift_exeparam_vaild), CW'(1'b0));

    // Flush overrides pending issue and push
    dispatch_info  = mk_info(3'b001, 50, 6, 0, 64'd5, 1'b1, 1'b0);
    dispatch_vaild = 1'b1;
    step();
    dispatch_info  = mk_info(3'b100, 51, 5, 0, 64'd6, 1'b1, 1'b0);
    flush          = 1'b1;
    step();
    flush          = 1'b0;
    dispatch_info  = mk_info(3'b100, 52, 5, 6, 64'hAB, 1'b0, 1'b1);
    smp();
    check("flush_vaild", CW'(shift_exeparam_vaild), CW'(1'b0));
    check("flush_ready", CW'(dispatch_ready), CW'(1'b1));
    check("flush_hold", CW'(shift_exeparam),
          CW'(mk_exe(stream_op(5), 45, 64'h1006, 64'd105, 1'b1)));
    step();
    dispatch_vaild = 1'b0;
    smp();
    check("flush_empty", CW'(shift_exeparam_vaild), CW'(1'b0));
    step();
    smp();
    check("post_flush_vaild", CW'(shift_exeparam_vaild), CW'(1'b1));
    check("post_flush_exe", CW'(shift_exeparam), CW'(mk_exe(3'b100, 52, 64'h1, 64'h1006, 1'b1)));
    step();
    smp();
    check("post_flush_idle", CW'(shift_exeparam_vaild), CW'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
